crack_job_scheduler: RTL and testbench
======================================

CRACK_JOB_SCHEDULER -- requirements
Module: crack_job_scheduler

Interface
REQ-001 Parameter NUM_ENGINES, default 4, number of brute-force search engines served.
REQ-002 Parameter CHUNK, default 4096, candidate indices per dispatched job.
REQ-003 Parameter KEYSPACE, default 1679616 (36^4), total candidate indices.
REQ-004 Port clk  in  1  single clock; all logic on rising edge.
REQ-005 Port rst  in  1  synchronous, active-high reset.
REQ-006 Port start  in  1  one-cycle pulse that launches a search; ignored unless state is IDLE or DONE.
REQ-007 Port busy  out  1  high in DISPATCH and DRAIN.
REQ-008 Port eng_req  in  NUM_ENGINES  engine i is idle and requests a job.
REQ-009 Port eng_grant  out  NUM_ENGINES  one-hot grant, one cycle wide.
REQ-010 Port job_base  out  21  first candidate index of the granted job, valid with eng_grant.
REQ-011 Port job_len  out  13  candidate count of the granted job (1..CHUNK), valid with eng_grant.
REQ-012 Port eng_hit  in  NUM_ENGINES  engine i found the password (one-cycle pulse).
REQ-013 Port eng_hit_idx  in  NUM_ENGINES*21  candidate index per engine, valid with its eng_hit bit.
REQ-014 Port eng_abort  out  1  one-cycle pulse telling all engines to drop current jobs.
REQ-015 Port done  out  1  one-cycle pulse when search ends.
REQ-016 Port found  out  1  held: last search hit; found_idx  out  21  held: winning candidate index.

Function
REQ-017 FSM states IDLE, DISPATCH, DRAIN, DONE; reset state IDLE.
REQ-018 IDLE/DONE + start -> DISPATCH; next_base := 0, found := 0, found_idx := 0.
REQ-019 DISPATCH: at most one grant per cycle, round-robin among eng_req bits, priority pointer moves to one past the last granted engine.
REQ-020 Grant: job_base = next_base, job_len = min(CHUNK, KEYSPACE - next_base); next_base += job_len same edge.
REQ-021 Grant and job outputs are registered: eng_req sampled in cycle N gives eng_grant in cycle N+1; an engine SHALL drop eng_req the cycle after its grant.
REQ-022 next_base == KEYSPACE -> DRAIN; no further grants.
REQ-023 DRAIN: when eng_req is all-ones (every engine idle) -> DONE with found = 0, done pulse.
REQ-024 Any eng_hit in DISPATCH or DRAIN -> found := 1, found_idx := hit index of lowest-numbered hitting engine, eng_abort pulse, done pulse, -> DONE next cycle.
REQ-025 Hit in same cycle as a pending grant: grant suppressed, hit wins.
REQ-026 eng_hit in IDLE or DONE ignored.
REQ-027 Last chunk truncated (KEYSPACE=10000, CHUNK=4096 -> lengths 4096, 4096, 1808); next_base never exceeds KEYSPACE.
REQ-028 start while busy ignored; no restart mid-search.

Reset
REQ-029 rst mid-search -> IDLE next edge; eng_grant=0, eng_abort=0, done=0, found=0, found_idx=0, job_base=0, job_len=0, busy=0, RR pointer=0, next_base=0.
REQ-030 Engines are reset by the same rst; scheduler issues no abort on reset.

Configuration
REQ-031 Macro CRACK_PERF_CNT_EN: defined -> extra output cycle_cnt (32 bits) counting clk cycles in DISPATCH+DRAIN, cleared on start and rst, held in DONE; undefined -> port absent, no counter logic.

Structure
REQ-032 Package crack_pkg: CHARSET_SIZE=36, PWD_LEN=4, KEYSPACE, IDX_W=21, LEN_W=13, state enum type.
REQ-033 Sub-module rr_arbiter (NUM_ENGINES-wide request in, one-hot grant out, pointer update on accept) instantiated once.

Verification
REQ-034 NUM_ENGINES=4, all eng_req=1, start -> grants to engines 0,1,2,3 on consecutive cycles, job_base 0,4096,8192,12288.
REQ-035 KEYSPACE=10000, CHUNK=4096, no hits -> three grants (len 4096,4096,1808), DRAIN, done with found=0 once all eng_req=1.
REQ-036 Engines 1 and 3 hit same cycle with idx 5000 and 13000 -> found=1, found_idx=5000, eng_abort and done pulse once, state DONE.
REQ-037 rst asserted in DISPATCH after 2 grants -> all outputs zero next cycle; subsequent start restarts at job_base 0.
REQ-038 start pulsed during DRAIN -> ignored; pulsed in DONE -> new search, found cleared, cycle_cnt (CRACK_PERF_CNT_EN) restarts at 0.

Source files
------------

// File: rtl/crack_pkg.sv
// Shared constants and types for the password-search job scheduler.
package crack_pkg;

  localparam int unsigned CHARSET_SIZE = 36;
  localparam int unsigned PWD_LEN      = 4;
  localparam int unsigned KEYSPACE     = CHARSET_SIZE ** PWD_LEN;
  localparam int unsigned IDX_W        = 21;
  localparam int unsigned LEN_W        = 13;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPATCH = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot pick, pointer moves past the winner on accept.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         accept_i,
  output logic [N-1:0] grant_c_o,
  output logic         any_c_o
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] win_c;
  logic [PW-1:0] idx_c;

  // Scan requests starting at the priority pointer; first hit wins.
  always_comb begin
    grant_c_o = '0;
    any_c_o   = 1'b0;
    win_c     = '0;
    idx_c     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx_c = PW'((32'(ptr_q) + k) % N);
      if (!any_c_o && req_i[idx_c]) begin
        any_c_o          = 1'b1;
        grant_c_o[idx_c] = 1'b1;
        win_c            = idx_c;
      end
    end
    ptr_d = PW'((32'(win_c) + 32'd1) % N);
  end

  // Priority pointer advances only when the pick is actually issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept_i && any_c_o) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/crack_job_scheduler.sv
// Hands out fixed-size index ranges to brute-force engines and stops on the first hit.
// Optional build macro CRACK_PERF_CNT_EN adds cycle_cnt (busy-cycle counter).
module crack_job_scheduler
  import crack_pkg::IDX_W;
  import crack_pkg::LEN_W;
  import crack_pkg::state_e;
  import crack_pkg::ST_IDLE;
  import crack_pkg::ST_DISPATCH;
  import crack_pkg::ST_DRAIN;
  import crack_pkg::ST_DONE;
#(
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned CHUNK       = 4096,
  parameter int unsigned KEYSPACE    = crack_pkg::KEYSPACE
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  input  logic [NUM_ENGINES-1:0]         eng_req,
  output logic [NUM_ENGINES-1:0]         eng_grant,
  output logic [IDX_W-1:0]               job_base,
  output logic [LEN_W-1:0]               job_len,
  input  logic [NUM_ENGINES-1:0]         eng_hit,
  input  logic [NUM_ENGINES*IDX_W-1:0]   eng_hit_idx,
  output logic                           eng_abort,
  output logic                           done,
  output logic                           found,
  output logic [IDX_W-1:0]               found_idx
`ifdef CRACK_PERF_CNT_EN
  ,
  output logic [31:0]                    cycle_cnt
`endif
);

  localparam logic [IDX_W-1:0] KS    = IDX_W'(KEYSPACE);
  localparam logic [IDX_W-1:0] CHK_I = IDX_W'(CHUNK);
  localparam logic [LEN_W-1:0] CHK_L = LEN_W'(CHUNK);

  state_e                 state_q;
  logic [IDX_W-1:0]       next_base_q;
  logic [IDX_W-1:0]       next_base_d;
  logic [IDX_W-1:0]       remain_c;
  logic [LEN_W-1:0]       job_len_c;
  logic [IDX_W-1:0]       hit_idx_c;
  logic [NUM_ENGINES-1:0] req_avail_c;
  logic [NUM_ENGINES-1:0] arb_grant_c;
  logic                   arb_any_c;
  logic                   arb_accept_c;
  logic                   any_hit_c;

  // An engine granted last cycle may still show eng_req this cycle; ignore it.
  assign req_avail_c  = eng_req & ~eng_grant;
  assign any_hit_c    = |eng_hit;
  assign arb_accept_c = (state_q == ST_DISPATCH) && !any_hit_c;

  rr_arbiter #(.N(NUM_ENGINES)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_avail_c),
    .accept_i  (arb_accept_c),
    .grant_c_o (arb_grant_c),
    .any_c_o   (arb_any_c)
  );

  // Next job size: a full chunk, or whatever remains of the keyspace.
  always_comb begin
    remain_c    = KS - next_base_q;
    job_len_c   = (remain_c < CHK_I) ? LEN_W'(remain_c) : CHK_L;
    next_base_d = next_base_q + IDX_W'(job_len_c);
  end

  // Winning index comes from the lowest-numbered engine reporting a hit.
  always_comb begin
    hit_idx_c = '0;
    for (int i = int'(NUM_ENGINES) - 1; i >= 0; i--) begin
      if (eng_hit[i]) hit_idx_c = eng_hit_idx[i*IDX_W +: IDX_W];
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      next_base_q <= '0;
      busy        <= 1'b0;
      eng_grant   <= '0;
      job_base    <= '0;
      job_len     <= '0;
      eng_abort   <= 1'b0;
      done        <= 1'b0;
      found       <= 1'b0;
      found_idx   <= '0;
    end else begin
      eng_grant <= '0;
      eng_abort <= 1'b0;
      done      <= 1'b0;
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_DISPATCH;
            busy        <= 1'b1;
            next_base_q <= '0;
            found       <= 1'b0;
            found_idx   <= '0;
          end
        end
        ST_DISPATCH, ST_DRAIN: begin
          if (any_hit_c) begin
            state_q   <= ST_DONE;
            busy      <= 1'b0;
            found     <= 1'b1;
            found_idx <= hit_idx_c;
            eng_abort <= 1'b1;
            done      <= 1'b1;
          end else if (state_q == ST_DISPATCH) begin
            if (arb_any_c) begin
              eng_grant   <= arb_grant_c;
              job_base    <= next_base_q;
              job_len     <= job_len_c;
              next_base_q <= next_base_d;
              if (next_base_d == KS) state_q <= ST_DRAIN;
            end
          end else if (&req_avail_c) begin
            state_q <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef CRACK_PERF_CNT_EN
  // Busy-cycle counter: cleared by a start that is accepted, frozen outside a search.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (start && (state_q == ST_IDLE || state_q == ST_DONE)) begin
      cycle_cnt <= '0;
    end else if (busy) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_crack_job_scheduler.sv
// Directed bench: full-keyspace instance (b_*) and a 10000-index instance (s_*) share inputs.
module tb_crack_job_scheduler;

  localparam int unsigned NE = 4;
  localparam int unsigned IW = 21;
  localparam int unsigned LW = 13;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [NE-1:0]  eng_req;
  logic [NE-1:0]  eng_hit;
  logic [NE*IW-1:0] eng_hit_idx;

  logic           b_busy, b_abort, b_done, b_found;
  logic [NE-1:0]  b_grant;
  logic [IW-1:0]  b_base, b_fidx;
  logic [LW-1:0]  b_len;
  logic           s_busy, s_abort, s_done, s_found;
  logic [NE-1:0]  s_grant;
  logic [IW-1:0]  s_base, s_fidx;
  logic [LW-1:0]  s_len;
`ifdef CRACK_PERF_CNT_EN
  logic [31:0]    b_cnt, s_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crack_job_scheduler #(.NUM_ENGINES(NE), .CHUNK(4096), .KEYSPACE(1679616)) u_big (
    .clk(clk), .rst(rst), .start(start), .busy(b_busy),
    .eng_req(eng_req), .eng_grant(b_grant), .job_base(b_base), .job_len(b_len),
    .eng_hit(eng_hit), .eng_hit_idx(eng_hit_idx), .eng_abort(b_abort),
    .done(b_done), .found(b_found), .found_idx(b_fidx)
`ifdef CRACK_PERF_CNT_EN
    , .cycle_cnt(b_cnt)
`endif
  );

  crack_job_scheduler #(.NUM_ENGINES(NE), .CHUNK(4096), .KEYSPACE(10000)) u_small (
    .clk(clk), .rst(rst), .start(start), .busy(s_busy),
    .eng_req(eng_req), .eng_grant(s_grant), .job_base(s_base), .job_len(s_len),
    .eng_hit(eng_hit), .eng_hit_idx(eng_hit_idx), .eng_abort(s_abort),
    .done(s_done), .found(s_found), .found_idx(s_fidx)
`ifdef CRACK_PERF_CNT_EN
    , .cycle_cnt(s_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; eng_req = '0; eng_hit = '0; eng_hit_idx = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", 32'(b_busy), 0);
    chk("rst_grant", 32'(b_grant), 0);
    chk("rst_done", 32'(b_done), 0);
    chk("rst_found", 32'(b_found), 0);
    chk("rst_base", 32'(b_base), 0);
    chk("rst_len", 32'(b_len), 0);

    // Launch with every engine requesting.
    eng_req = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", 32'(b_busy), 1);
    chk("start_nogrant", 32'(b_grant), 0);

    for (int k = 0; k < 4; k++) begin
      tick();
      chk("b_grant", 32'(b_grant), 32'(1 << k));
      chk("b_base", 32'(b_base), 32'(k * 4096));
      chk("b_len", 32'(b_len), 4096);
      if (k < 3) begin
        chk("s_grant", 32'(s_grant), 32'(1 << k));
        chk("s_base", 32'(s_base), 32'(k * 4096));
        chk("s_len", 32'(s_len), (k == 2) ? 32'd1808 : 32'd4096);
      end else begin
        chk("s_drain_nogrant", 32'(s_grant), 0);
        chk("s_drain_busy", 32'(s_busy), 1);
        chk("s_drain_nodone", 32'(s_done), 0);
      end
    end
    tick();
    chk("s_done", 32'(s_done), 1);
    chk("s_found0", 32'(s_found), 0);
    chk("s_idle_busy", 32'(s_busy), 0);
    chk("b_wrap_grant", 32'(b_grant), 1);
    chk("b_wrap_base", 32'(b_base), 16384);
    tick();
    chk("s_done_once", 32'(s_done), 0);
    chk("b_grant1", 32'(b_grant), 2);

    // Engines 1 and 3 hit together while a grant is pending.
    eng_hit = 4'b1010;
    eng_hit_idx[1*IW +: IW] = 21'd5000;
    eng_hit_idx[3*IW +: IW] = 21'd13000;
    tick();
    eng_hit = '0;
    chk("hit_found", 32'(b_found), 1);
    chk("hit_idx", 32'(b_fidx), 5000);
    chk("hit_abort", 32'(b_abort), 1);
    chk("hit_done", 32'(b_done), 1);
    chk("hit_nogrant", 32'(b_grant), 0);
    chk("hit_busy", 32'(b_busy), 0);
    chk("s_hit_ignored", 32'(s_found), 0);
    chk("s_hit_noabort", 32'(s_abort), 0);
    tick();
    chk("abort_once", 32'(b_abort), 0);
    chk("done_once", 32'(b_done), 0);
    chk("found_held", 32'(b_found), 1);

    // Hit while DONE is ignored.
    eng_hit = 4'b0001;
    eng_hit_idx[0 +: IW] = 21'd77;
    tick();
    eng_hit = '0;
    chk("done_hit_idx", 32'(b_fidx), 5000);
    chk("done_hit_nodone", 32'(b_done), 0);

    // Restart from DONE clears the result and restarts at base 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("re_busy", 32'(b_busy), 1);
    chk("re_found", 32'(b_found), 0);
    chk("re_fidx", 32'(b_fidx), 0);
`ifdef CRACK_PERF_CNT_EN
    chk("re_cnt0", b_cnt, 0);
`endif
    tick();
    chk("re_grant", 32'(b_grant), 4);
    chk("re_base", 32'(b_base), 0);
    chk("s_re_grant", 32'(s_grant), 8);
`ifdef CRACK_PERF_CNT_EN
    chk("re_cnt1", b_cnt, 1);
`endif
    tick();
    chk("re_base2", 32'(b_base), 4096);
    tick();
    chk("s_last_len", 32'(s_len), 1808);

    // Start while busy (big in DISPATCH, small in DRAIN) is ignored.
    eng_req = 4'b0111; start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_base", 32'(b_base), 12288);
    chk("busy_start_grant", 32'(b_grant), 2);
    chk("drain_start_busy", 32'(s_busy), 1);
    chk("drain_start_done", 32'(s_done), 0);
    eng_req = 4'hF;
    tick();
    chk("drain_done", 32'(s_done), 1);
    chk("drain_found", 32'(s_found), 0);

    // Reset in the middle of dispatch.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_grant", 32'(b_grant), 0);
    chk("mrst_base", 32'(b_base), 0);
    chk("mrst_len", 32'(b_len), 0);
    chk("mrst_busy", 32'(b_busy), 0);
    chk("mrst_abort", 32'(b_abort), 0);
`ifdef CRACK_PERF_CNT_EN
    chk("mrst_cnt", b_cnt, 0);
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("post_rst_grant", 32'(b_grant), 1);
    chk("post_rst_base", 32'(b_base), 0);
    chk("post_rst_len", 32'(b_len), 4096);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
